// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and defaults for the memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, WR_BUSY, RD_BUSY)
//   req_id_t    : requester identity (REQ_WR, REQ_RD)
//   DEF_QUOTA, DEF_MAX_STARVE : default fairness limits
//   other_req() : returns the requester that is not the one given
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_WR = 1'b0,
    REQ_RD = 1'b1
  } req_id_t;

  localparam int DEF_QUOTA      = 4;
  localparam int DEF_MAX_STARVE = 16;

  function automatic req_id_t other_req(input req_id_t id);
    if (id == REQ_WR) return REQ_RD;
    return REQ_WR;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Combinational grant decision for the memory port arbiter.
// Ports:
//   wr_req, rd_req  : pending requests
//   wr_urgent       : write side asks for priority
//   quota_cnt       : consecutive grants to last_served (0 = no turn in progress)
//   starve_cnt      : write grants made while a read was waiting
//   last_served     : requester granted most recently
//   pick_valid      : at least one requester is asking
//   pick_id         : requester to grant next
//   pick_urgent     : decision was made by the urgent-write override
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int QUOTA      = DEF_QUOTA,
  parameter int MAX_STARVE = DEF_MAX_STARVE,
  parameter int QW         = $clog2(QUOTA + 1),
  parameter int SW         = $clog2(MAX_STARVE + 1)
) (
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic          wr_urgent,
  input  logic [QW-1:0] quota_cnt,
  input  logic [SW-1:0] starve_cnt,
  input  req_id_t       last_served,
  output logic          pick_valid,
  output req_id_t       pick_id,
  output logic          pick_urgent
);

  always_comb begin
    pick_valid  = wr_req | rd_req;
    pick_id     = REQ_WR;
    pick_urgent = 1'b0;
    if (wr_req && !rd_req) begin
      pick_id = REQ_WR;
    end else if (rd_req && !wr_req) begin
      pick_id = REQ_RD;
    end else if (starve_cnt == SW'(MAX_STARVE)) begin
      pick_id = REQ_RD;
    end else if (wr_urgent) begin
      pick_id     = REQ_WR;
      pick_urgent = 1'b1;
    end else if (quota_cnt != '0 && quota_cnt < QW'(QUOTA)) begin
      // A zero count means no turn is in progress (just out of reset),
      // so the tie falls through to the other side and write goes first.
      pick_id = last_served;
    end else begin
      pick_id = other_req(last_served);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory controller command port between the camera write
// sequencer and the display read sequencer. One transaction at a time;
// round-robin with per-turn quota, urgent write override and a read
// starvation guard.
// Ports:
//   ctrl_clk, reset (async, active high)
//   wr_req/wr_addr/wr_data/wr_urgent -> wr_waitrequest
//   rd_req/rd_addr -> rd_waitrequest, rd_data, rd_valid
//   mem_addr/mem_write/mem_read/mem_wdata -> memory, mem_rdata/mem_waitrequest <- memory
//   grant_wr/grant_rd : registered ownership flags
// Optional: define MEM_ARB_STATS_EN to add wr_grant_cnt, rd_grant_cnt
// and urgent_cnt (completed writes, completed reads, urgent-override grants).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int QUOTA      = DEF_QUOTA,
  parameter int MAX_STARVE = DEF_MAX_STARVE
) (
  input  logic              ctrl_clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_urgent,
  output logic              wr_waitrequest,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_waitrequest,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_waitrequest,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0]       wr_grant_cnt,
  output logic [31:0]       rd_grant_cnt,
  output logic [31:0]       urgent_cnt,
`endif
  output logic              grant_wr,
  output logic              grant_rd
);

  localparam int QW = $clog2(QUOTA + 1);
  localparam int SW = $clog2(MAX_STARVE + 1);

  arb_state_t    state_reg;
  logic [QW-1:0] quota_cnt_reg;
  logic [SW-1:0] starve_cnt_reg;
  req_id_t       last_served_reg;

  logic    pick_valid;
  req_id_t pick_id;
  logic    pick_urgent;
  logic    wr_cmpl;
  logic    rd_cmpl;

  mem_arb_pick #(
    .QUOTA      (QUOTA),
    .MAX_STARVE (MAX_STARVE),
    .QW         (QW),
    .SW         (SW)
  ) u_pick (
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .wr_urgent   (wr_urgent),
    .quota_cnt   (quota_cnt_reg),
    .starve_cnt  (starve_cnt_reg),
    .last_served (last_served_reg),
    .pick_valid  (pick_valid),
    .pick_id     (pick_id),
    .pick_urgent (pick_urgent)
  );

  // Completion is the memory dropping waitrequest while we own the port;
  // the owner sees its own waitrequest low for that single cycle.
  assign wr_cmpl        = (state_reg == WR_BUSY) && !mem_waitrequest;
  assign rd_cmpl        = (state_reg == RD_BUSY) && !mem_waitrequest;
  assign wr_waitrequest = !wr_cmpl;
  assign rd_waitrequest = !rd_cmpl;

  always_ff @(posedge ctrl_clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      grant_wr        <= 1'b0;
      grant_rd        <= 1'b0;
      mem_write       <= 1'b0;
      mem_read        <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      rd_data         <= '0;
      rd_valid        <= 1'b0;
      quota_cnt_reg   <= '0;
      starve_cnt_reg  <= '0;
      last_served_reg <= REQ_RD;
    end else begin
      rd_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            // Requesters hold address/data stable until accepted, so a
            // copy taken at grant time is what the memory must see.
            if (pick_id == REQ_WR) begin
              state_reg <= WR_BUSY;
              grant_wr  <= 1'b1;
              mem_write <= 1'b1;
              mem_addr  <= wr_addr;
              mem_wdata <= wr_data;
            end else begin
              state_reg <= RD_BUSY;
              grant_rd  <= 1'b1;
              mem_read  <= 1'b1;
              mem_addr  <= rd_addr;
            end
            if (pick_id != last_served_reg)
              quota_cnt_reg <= QW'(1);
            else if (quota_cnt_reg != QW'(QUOTA))
              quota_cnt_reg <= quota_cnt_reg + QW'(1);
            if (pick_id == REQ_RD)
              starve_cnt_reg <= '0;
            else if (rd_req && starve_cnt_reg != SW'(MAX_STARVE))
              starve_cnt_reg <= starve_cnt_reg + SW'(1);
            last_served_reg <= pick_id;
          end
        end
        WR_BUSY: begin
          if (!mem_waitrequest) begin
            state_reg <= IDLE;
            grant_wr  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        RD_BUSY: begin
          if (!mem_waitrequest) begin
            state_reg <= IDLE;
            grant_rd  <= 1'b0;
            mem_read  <= 1'b0;
            rd_data   <= mem_rdata;
            rd_valid  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_wr  <= 1'b0;
          grant_rd  <= 1'b0;
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge ctrl_clk or posedge reset) begin
    if (reset) begin
      wr_grant_cnt <= '0;
      rd_grant_cnt <= '0;
      urgent_cnt   <= '0;
    end else begin
      if (wr_cmpl) wr_grant_cnt <= wr_grant_cnt + 32'd1;
      if (rd_cmpl) rd_grant_cnt <= rd_grant_cnt + 32'd1;
      if (state_reg == IDLE && pick_valid && pick_urgent)
        urgent_cnt <= urgent_cnt + 32'd1;
    end
  end
`else
  logic unused_pick_urgent;
  assign unused_pick_urgent = pick_urgent;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int QUOTA      = 4;
  localparam int MAX_STARVE = 16;

  logic        ctrl_clk;
  logic        reset;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_urgent;
  logic        wr_waitrequest;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_waitrequest;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_waitrequest;
  logic        grant_wr;
  logic        grant_rd;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] wr_grant_cnt;
  logic [31:0] rd_grant_cnt;
  logic [31:0] urgent_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .QUOTA      (QUOTA),
    .MAX_STARVE (MAX_STARVE)
  ) dut (
    .ctrl_clk        (ctrl_clk),
    .reset           (reset),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_urgent       (wr_urgent),
    .wr_waitrequest  (wr_waitrequest),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_waitrequest  (rd_waitrequest),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .mem_addr        (mem_addr),
    .mem_write       (mem_write),
    .mem_read        (mem_read),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_waitrequest (mem_waitrequest),
`ifdef MEM_ARB_STATS_EN
    .wr_grant_cnt    (wr_grant_cnt),
    .rd_grant_cnt    (rd_grant_cnt),
    .urgent_cnt      (urgent_cnt),
`endif
    .grant_wr        (grant_wr),
    .grant_rd        (grant_rd)
  );

  initial ctrl_clk = 1'b0;
  always #5 ctrl_clk = ~ctrl_clk;

  // One entry per grant: who got the port, and whether a read was waiting.
  typedef struct packed {
    logic is_rd;
    logic rd_pend;
  } grant_t;
  grant_t hist[$];

  int n_checks = 0;
  int n_fail   = 0;

  int   wr_left, rd_left;
  bit   rand_mode, urg_fixed, rdata_fixed;
  logic [31:0] fixed_rdata;
  int   lat_fixed, lat_cur, age;
  bit   busy_prev, done_prev, pend_rdv, wr_done, rd_done;
  logic [31:0] pend_rdata;
  logic drv_wr, drv_rd, drv_urg;
  int   mw_cnt, wr_low_cnt, rdv_cnt;
  bit   rd_grant_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration from grant history: run length gives the quota
  // position, writes-with-read-waiting since the last read give starvation.
  function automatic logic model_pick_rd(input logic w, input logic r, input logic u);
    int   starve = 0;
    int   run = 0;
    logic last;
    if (w && !r) return 1'b0;
    if (r && !w) return 1'b1;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].is_rd) break;
      if (hist[i].rd_pend) starve++;
    end
    if (starve >= MAX_STARVE) return 1'b1;
    if (u) return 1'b0;
    if (hist.size() == 0) return 1'b0;
    last = hist[hist.size() - 1].is_rd;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].is_rd != last) break;
      run++;
    end
    return (run < QUOTA) ? last : !last;
  endfunction

  task automatic clear_model();
    hist.delete();
    busy_prev = 0; done_prev = 0; pend_rdv = 0;
    wr_done = 0; rd_done = 0; age = 0;
    drv_wr = wr_req; drv_rd = rd_req; drv_urg = wr_urgent;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0; wr_urgent = 1'b0;
    mem_waitrequest = 1'b1;
    wr_left = 0; rd_left = 0; urg_fixed = 0; rand_mode = 0;
    repeat (2) @(posedge ctrl_clk);
    #1 reset = 1'b0;
    clear_model();
  endtask

  task automatic cycle();
    logic busy;
    grant_t g;
    @(posedge ctrl_clk);
    #1;
    busy = grant_wr | grant_rd;
    check("rd_valid", 64'(rd_valid), 64'(pend_rdv));
    if (pend_rdv) check("rd_data", 64'(rd_data), 64'(pend_rdata));
    if (rd_valid) rdv_cnt++;
    if (mem_write) mw_cnt++;
    if (grant_rd) rd_grant_seen = 1;
    if (done_prev) check("idle_gap", 64'(busy), 64'(0));
    check("grant_excl", 64'(grant_wr & grant_rd), 64'(0));
    check("mem_write_vs_grant", 64'(mem_write), 64'(grant_wr));
    check("mem_read_vs_grant", 64'(mem_read), 64'(grant_rd));
    if (busy && !busy_prev) begin
      check("grant_cause", 64'(drv_wr | drv_rd), 64'(1));
      check("grant_pick", 64'(grant_rd), 64'(model_pick_rd(drv_wr, drv_rd, drv_urg)));
      if (grant_wr) begin
        check("wr_mem_addr", 64'(mem_addr), 64'(wr_addr));
        check("wr_mem_wdata", 64'(mem_wdata), 64'(wr_data));
      end else begin
        check("rd_mem_addr", 64'(mem_addr), 64'(rd_addr));
      end
      g.is_rd = grant_rd;
      g.rd_pend = drv_rd;
      hist.push_back(g);
      $display("grant #%0d: %s (wr_req=%0b rd_req=%0b urgent=%0b)",
               hist.size(), grant_rd ? "RD" : "WR", drv_wr, drv_rd, drv_urg);
    end
    busy_prev = busy;
    pend_rdv = 0;
    if (wr_done) begin wr_left--; wr_addr = $urandom; wr_data = $urandom; end
    if (rd_done) begin rd_left--; rd_addr = $urandom; end
    wr_done = 0; rd_done = 0;
    if (rand_mode) begin
      if (wr_left == 0 && $urandom_range(0, 2) == 0) wr_left = 1;
      if (rd_left == 0 && $urandom_range(0, 2) == 0) rd_left = 1;
      if ($urandom_range(0, 19) == 0) urg_fixed = !urg_fixed;
    end
    wr_req = (wr_left > 0);
    rd_req = (rd_left > 0);
    wr_urgent = urg_fixed;
    drv_wr = wr_req; drv_rd = rd_req; drv_urg = wr_urgent;
    if (mem_read || mem_write) begin
      age++;
      if (age == 1) lat_cur = rand_mode ? int'($urandom_range(1, 3)) : lat_fixed;
    end else begin
      age = 0;
    end
    mem_waitrequest = !((mem_read || mem_write) && age == lat_cur);
    mem_rdata = rdata_fixed ? fixed_rdata : $urandom;
    #1;
    check("wr_waitrequest", 64'(wr_waitrequest), 64'(!(grant_wr && !mem_waitrequest)));
    check("rd_waitrequest", 64'(rd_waitrequest), 64'(!(grant_rd && !mem_waitrequest)));
    done_prev = 0;
    if (!wr_waitrequest) begin wr_done = 1; wr_low_cnt++; done_prev = 1; end
    if (!rd_waitrequest) begin rd_done = 1; pend_rdv = 1; pend_rdata = mem_rdata; done_prev = 1; end
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while ((wr_left != 0 || rd_left != 0 || grant_wr || grant_rd) && n < bound) begin
      cycle();
      n++;
    end
    check({tag, "_timeout"}, 64'(n < bound), 64'(1));
    cycle();
  endtask

  initial begin
    int n;
    wr_addr = $urandom; wr_data = $urandom; rd_addr = $urandom; mem_rdata = '0;
    rdata_fixed = 0; fixed_rdata = '0; lat_fixed = 1; lat_cur = 1;
    mw_cnt = 0; wr_low_cnt = 0; rdv_cnt = 0; rd_grant_seen = 0;

    // Reset values
    do_reset();
    check("rst_grant_wr", 64'(grant_wr), 64'(0));
    check("rst_grant_rd", 64'(grant_rd), 64'(0));
    check("rst_mem_read", 64'(mem_read), 64'(0));
    check("rst_mem_write", 64'(mem_write), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_wr_waitreq", 64'(wr_waitrequest), 64'(1));
    check("rst_rd_waitreq", 64'(rd_waitrequest), 64'(1));

    // Single write, memory completes on the third command cycle
    lat_fixed = 3; mw_cnt = 0; wr_low_cnt = 0; rd_grant_seen = 0;
    wr_left = 1;
    drain("t_wr_only", 40);
    check("t_wr_only_mem_write_cycles", 64'(mw_cnt), 64'(3));
    check("t_wr_only_waitreq_lows", 64'(wr_low_cnt), 64'(1));
    check("t_wr_only_no_rd_grant", 64'(rd_grant_seen), 64'(0));

    // Both requesting, no urgent: quota round-robin, write first
    do_reset();
    lat_fixed = 1; wr_left = 12; rd_left = 12;
    drain("t_quota", 400);
    check("t_quota_count", 64'(hist.size()), 64'(24));
    for (int i = 0; i < 24 && i < hist.size(); i++)
      check($sformatf("t_quota_order_%0d", i), 64'(hist[i].is_rd), 64'((i / QUOTA) % 2));

    // Urgent writes with a waiting read: starvation guard forces one read
    do_reset();
    lat_fixed = 1; urg_fixed = 1; wr_left = 40; rd_left = 3;
    drain("t_starve", 600);
    urg_fixed = 0;
    check("t_starve_count", 64'(hist.size()), 64'(43));
    for (int i = 0; i < 34 && i < hist.size(); i++)
      check($sformatf("t_starve_order_%0d", i), 64'(hist[i].is_rd),
            64'((i % (MAX_STARVE + 1)) == MAX_STARVE));

    // Read data capture and single-cycle rd_valid
    do_reset();
    rdata_fixed = 1; fixed_rdata = 32'hDEADBEEF; lat_fixed = 2; rdv_cnt = 0;
    rd_left = 1;
    drain("t_rdata", 40);
    check("t_rdata_valid_pulses", 64'(rdv_cnt), 64'(1));
    check("t_rdata_value", 64'(rd_data), 64'(32'hDEADBEEF));
    rdata_fixed = 0;

    // Asynchronous reset during a read, then both requesting at exit
    do_reset();
    lat_fixed = 1000; rd_left = 1;
    n = 0;
    while (!grant_rd && n < 20) begin cycle(); n++; end
    check("t_arst_rd_granted", 64'(grant_rd), 64'(1));
    cycle();
    #2 reset = 1'b1;
    #1;
    check("t_arst_mem_read", 64'(mem_read), 64'(0));
    check("t_arst_grant_rd", 64'(grant_rd), 64'(0));
    check("t_arst_rd_waitreq", 64'(rd_waitrequest), 64'(1));
    @(posedge ctrl_clk);
    #1;
    lat_fixed = 1; wr_left = 1; rd_left = 1;
    wr_req = 1'b1; rd_req = 1'b1; wr_urgent = 1'b0;
    reset = 1'b0;
    clear_model();
    drain("t_arst", 60);
    check("t_arst_two_grants", 64'(hist.size()), 64'(2));
    check("t_arst_first_is_wr", 64'((hist.size() > 0) ? hist[0].is_rd : 1'b1), 64'(0));

    // Randomized traffic against the reference model
    do_reset();
    rand_mode = 1;
    repeat (1500) cycle();
    rand_mode = 0; urg_fixed = 0;
    drain("t_random", 200);
    $display("random phase: %0d grants", hist.size());

`ifdef MEM_ARB_STATS_EN
    do_reset();
    lat_fixed = 2; wr_left = 5; rd_left = 3;
    drain("t_stats", 200);
    check("t_stats_wr", 64'(wr_grant_cnt), 64'(5));
    check("t_stats_rd", 64'(rd_grant_cnt), 64'(3));
    check("t_stats_urgent", 64'(urgent_cnt), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory controller command port (addr/read/write/waitrequest) between two requesters:
  - the write sequencer, which drains camera data into DRAM;
  - the read sequencer, which refills the display FIFO from DRAM.
- Grants one transaction at a time.
- Uses round-robin with a per-turn quota, an urgent override for the write side and a starvation guard for the read side.
- Sits between both sequencers and the memory system instance, in the controller clock domain.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- QUOTA, 4, maximum consecutive grants to one requester while the other is requesting.
- MAX_STARVE, 16, maximum consecutive write grants under urgent override before one read grant is forced.

Ports:
- ctrl_clk  in  1  controller clock.
- reset  in  1  asynchronous, active-high reset.
- wr_req  in  1  write request; held with wr_addr/wr_data stable until accepted.
- wr_addr  in  ADDR_W  write byte address.
- wr_data  in  DATA_W  write data.
- wr_urgent  in  1  write FIFO above threshold; requests priority.
- wr_waitrequest  out  1  low for exactly the cycle the write completes.
- rd_req  in  1  read request; held with rd_addr stable until accepted.
- rd_addr  in  ADDR_W  read byte address.
- rd_waitrequest  out  1  low for exactly the cycle the read completes.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse, one cycle after read completion.
- mem_addr  out  ADDR_W  to memory port.
- mem_write  out  1  to memory port.
- mem_read  out  1  to memory port.
- mem_wdata  out  DATA_W  to memory port.
- mem_rdata  in  DATA_W  from memory port.
- mem_waitrequest  in  1  from memory port; low marks command completion.
- grant_wr  out  1  registered; write owns the port.
- grant_rd  out  1  registered; read owns the port.

Behaviour:
- Reset values: state IDLE, grant_wr=0, grant_rd=0, mem_read=0, mem_write=0, rd_valid=0, rd_data=0. Quota/starve counters 0; last-served = read, so write wins the first tie.
- Asynchronous reset mid-transaction: mem_read/mem_write deassert immediately and the in-flight transaction is abandoned. Requesters must reissue.
- States:
  - IDLE: decision point.
  - WR_BUSY: mem_write=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - RD_BUSY: mem_read=1, mem_addr=rd_addr.
- Outside the BUSY states, mem_addr and mem_wdata hold their last values.
- Decision in IDLE (registered; a command appears the cycle after the request is sampled), in priority order:
  - (a) only one requester active → grant it;
  - (b) rd_req and starve_cnt==MAX_STARVE → read;
  - (c) wr_urgent and wr_req → write;
  - (d) last-served requester has quota_cnt<QUOTA → same requester again;
  - (e) otherwise → the other requester.
- Counter updates on each grant:
  - Same requester as last: quota_cnt increments, saturating at QUOTA. Switching requester resets it to 1.
  - Write grant made with rd_req high: starve_cnt increments. Any read grant clears it.
- Completion:
  - BUSY state with mem_waitrequest=0 drives the granted requester's waitrequest low for that single cycle, then returns to IDLE.
  - Non-granted requester waitrequest is always 1.
  - No back-to-back commands: minimum 1 IDLE cycle between transactions.
- Read completion: rd_data <= mem_rdata and rd_valid=1 on the next cycle, for one cycle only.
- Request withdrawn while granted: not permitted (protocol violation). The arbiter completes the transaction regardless.
- Simultaneous wr_req and rd_req at reset exit: write served first.
- mem_waitrequest held high indefinitely: the arbiter stays in its BUSY state. There is no timeout.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs wr_grant_cnt[31:0], rd_grant_cnt[31:0] and urgent_cnt[31:0], counting completed transactions and urgent-override grants.
  - All three wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, WR_BUSY, RD_BUSY};
  - requester id typedef {REQ_WR, REQ_RD};
  - default QUOTA/MAX_STARVE constants.
- One sub-module: mem_arb_pick. Combinational decision logic taking requests, urgent, counters and last-served, and producing the next grant. It is unit-testable alone.

Test Plan:
- Write only, mem_waitrequest low after 3 cycles → mem_write high 3 cycles, wr_waitrequest low exactly once, grant_rd=0 throughout.
- Both requesting continuously, QUOTA=4, no urgent, 1-cycle memory → grant order W,W,W,W,R,R,R,R,W... (write first).
- wr_urgent held with both requesting, MAX_STARVE=16 → 16 consecutive writes, then exactly 1 read, then writes resume.
- Read with mem_rdata=32'hDEADBEEF on completion → rd_valid single pulse next cycle, rd_data=32'hDEADBEEF.
- Reset asserted while in RD_BUSY → mem_read drops in the same cycle (asynchronous), state IDLE. The first grant after release is write if both are requesting.
- MEM_ARB_STATS_EN defined, 5 writes + 3 reads → wr_grant_cnt=5, rd_grant_cnt=3, urgent_cnt=0.
